// File: rtl/ntru_pkg.sv
// Shared constants and types for the NTRU-HRSS trit serialization path.
package ntru_pkg;

   localparam int unsigned N_COEF      = 701;
   localparam int unsigned TRIT_W      = 2;
   localparam int unsigned GROUP_TRITS = 5;
   localparam int unsigned N_GROUPS    = (N_COEF + GROUP_TRITS - 1) / GROUP_TRITS;
   localparam int unsigned GRP_W       = TRIT_W * GROUP_TRITS;

   typedef enum logic [TRIT_W-1:0] {
      T_ZERO = 2'b00,
      T_POS  = 2'b01,
      T_NEG  = 2'b10
   } trit_e;

   typedef logic [GRP_W-1:0] grp_t;

   // The unused 11 code point is stored as zero; the caller flags it separately.
   function automatic trit_e trit_sanitize(logic [TRIT_W-1:0] t);
      return (t == 2'b11) ? T_ZERO : trit_e'(t);
   endfunction

endpackage

// File: rtl/grp_out_reg.sv
// Held output register for completed trit groups: valid/ready hold and drain,
// last-group qualifier and the registered end-of-polynomial pulse.
module grp_out_reg
   import ntru_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [GRP_W-1:0] load_grp,
   input  logic             load_last,
   input  logic             out_ready,
   output logic             free,
   output logic             out_valid,
   output logic [GRP_W-1:0] out_grp,
   output logic             out_last,
   output logic             poly_done
);

   logic             valid_q;
   logic [GRP_W-1:0] grp_q;
   logic             last_q;
   logic             done_q;

   assign free      = ~valid_q | out_ready;
   assign out_valid = valid_q;
   assign out_grp   = grp_q;
   assign out_last  = last_q;
   assign poly_done = done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         grp_q   <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= valid_q & out_ready & last_q;
         if (load) begin
            valid_q <= 1'b1;
            grp_q   <= load_grp;
            last_q  <= load_last;
         end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/trit_group_packer.sv
// Collects one trit per cycle into 5-trit groups, zero-pads the last group of
// each polynomial and hands groups to a held output register with backpressure.
module trit_group_packer #(
   parameter int unsigned N_COEF = ntru_pkg::N_COEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_trit,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [9:0] out_grp,
   output logic       out_last,
   output logic       poly_done,
   output logic       err
);

   import ntru_pkg::*;

   localparam int unsigned CW = (N_COEF > 1) ? $clog2(N_COEF) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N_COEF - 1);
   localparam logic [2:0] LAST_SLOT = 3'(GROUP_TRITS - 1);

   logic [2:0]    slot_q;
   logic [CW-1:0] coef_q;
   grp_t          acc_q;
   logic          pending_q;
   logic          pend_last_q;
   logic          err_q;

   grp_t  acc_new;
   grp_t  load_grp;
   trit_e trit_w;
   logic  accept;
   logic  is_last;
   logic  complete;
   logic  free;
   logic  load;
   logic  load_last;

   assign in_ready  = ~pending_q;
   assign err       = err_q;
   assign accept    = in_valid & ~pending_q;
   assign is_last   = (coef_q == LAST_IDX);
   assign complete  = accept & ((slot_q == LAST_SLOT) | is_last);
   assign load      = (complete | pending_q) & free;
   assign trit_w    = trit_sanitize(in_trit);
   assign load_grp  = pending_q ? acc_q : acc_new;
   assign load_last = pending_q ? pend_last_q : is_last;

   always_comb begin
      acc_new = acc_q;
      for (int i = 0; i < GROUP_TRITS; i++) begin
         if (slot_q == 3'(i)) acc_new[TRIT_W*i +: TRIT_W] = trit_w;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_q      <= '0;
         coef_q      <= '0;
         acc_q       <= '0;
         pending_q   <= 1'b0;
         pend_last_q <= 1'b0;
         err_q       <= 1'b0;
      end else if (accept) begin
         if (in_trit == 2'b11) err_q <= 1'b1;
         if (complete) begin
            slot_q <= '0;
            coef_q <= is_last ? '0 : coef_q + 1'b1;
            // A group that cannot move out stays parked here and blocks input.
            if (load) begin
               acc_q <= '0;
            end else begin
               acc_q       <= acc_new;
               pending_q   <= 1'b1;
               pend_last_q <= is_last;
            end
         end else begin
            slot_q <= slot_q + 1'b1;
            coef_q <= coef_q + 1'b1;
            acc_q  <= acc_new;
         end
      end else if (pending_q && free) begin
         pending_q <= 1'b0;
         acc_q     <= '0;
      end
   end

   grp_out_reg u_grp_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_grp  (load_grp),
      .load_last (load_last),
      .out_ready (out_ready),
      .free      (free),
      .out_valid (out_valid),
      .out_grp   (out_grp),
      .out_last  (out_last),
      .poly_done (poly_done)
   );

endmodule

// File: tb/tb_trit_group_packer.sv
// Directed bench for trit_group_packer: default 701-coefficient instance plus
// a 7-coefficient instance for the short-polynomial padding case.
module tb_trit_group_packer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] in_trit = 2'b00;
   logic       out_ready = 1'b1;

   logic       in_ready_a, out_valid_a, out_last_a, poly_done_a, err_a;
   logic [9:0] out_grp_a;
   logic       in_ready_b, out_valid_b, out_last_b, poly_done_b, err_b;
   logic [9:0] out_grp_b;

   int n_checks = 0;
   int n_fail   = 0;
   int pd_a     = 0;
   logic use_b  = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) if (poly_done_a) pd_a <= pd_a + 1;

   trit_group_packer u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a),
      .in_trit   (in_trit),
      .out_valid (out_valid_a),
      .out_ready (out_ready),
      .out_grp   (out_grp_a),
      .out_last  (out_last_a),
      .poly_done (poly_done_a),
      .err       (err_a)
   );

   trit_group_packer #(.N_COEF(7)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_b),
      .in_trit   (in_trit),
      .out_valid (out_valid_b),
      .out_ready (out_ready),
      .out_grp   (out_grp_b),
      .out_last  (out_last_b),
      .poly_done (poly_done_b),
      .err       (err_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic send(input logic [1:0] t);
      int n = 0;
      in_valid = 1'b1;
      in_trit  = t;
      while (!(use_b ? in_ready_b : in_ready_a) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("in_ready_wait", 32'(use_b ? in_ready_b : in_ready_a), 32'd1);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] seq1 [5];
      seq1 = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10};

      // Reset state
      do_reset();
      check("rst_out_valid", 32'(out_valid_a), 32'd0);
      check("rst_out_grp", 32'(out_grp_a), 32'd0);
      check("rst_err", 32'(err_a), 32'd0);
      check("rst_in_ready", 32'(in_ready_a), 32'd1);
      check("rst_poly_done", 32'(poly_done_a), 32'd0);

      // First group, unthrottled
      out_ready = 1'b1;
      foreach (seq1[i]) send(seq1[i]);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("g1_valid", 32'(out_valid_a), 32'd1);
      check("g1_grp", 32'(out_grp_a), 32'h249);
      check("g1_last", 32'(out_last_a), 32'd0);

      // Second group completes while the first is held
      for (int i = 0; i < 5; i++) send(2'b00);
      in_valid = 1'b0;
      check("pend_in_ready", 32'(in_ready_a), 32'd0);
      check("hold_grp", 32'(out_grp_a), 32'h249);
      @(negedge clk);
      check("hold_grp2", 32'(out_grp_a), 32'h249);
      check("hold_valid", 32'(out_valid_a), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      check("g2_grp", 32'(out_grp_a), 32'h000);
      check("g2_valid", 32'(out_valid_a), 32'd1);
      check("g2_in_ready", 32'(in_ready_a), 32'd1);
      @(negedge clk);
      check("drain_valid", 32'(out_valid_a), 32'd0);

      // Full polynomial of +1 trits
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 701; i++) begin
         send(2'b01);
         if (i % 5 == 0) check("poly_grp", {21'd0, out_last_a, out_grp_a}, 32'h155);
         else if (i == 701) check("poly_final", {21'd0, out_last_a, out_grp_a}, 32'h401);
      end
      in_valid = 1'b0;
      check("pre_done_pd", 32'(pd_a), 32'd0);
      @(negedge clk);
      check("poly_done_hi", 32'(poly_done_a), 32'd1);
      @(negedge clk);
      check("poly_done_lo", 32'(poly_done_a), 32'd0);
      check("poly_done_count", 32'(pd_a), 32'd1);
      for (int i = 0; i < 5; i++) send(2'b01);
      in_valid = 1'b0;
      check("next_poly_grp", {21'd0, out_last_a, out_grp_a}, 32'h155);

      // Illegal trit in slot 2
      do_reset();
      send(2'b01); send(2'b01); send(2'b11); send(2'b01); send(2'b01);
      in_valid = 1'b0;
      check("illegal_grp", 32'(out_grp_a), 32'h145);
      check("illegal_err", 32'(err_a), 32'd1);
      for (int i = 0; i < 5; i++) send(2'b01);
      in_valid = 1'b0;
      check("err_sticky_grp", 32'(out_grp_a), 32'h155);
      check("err_sticky", 32'(err_a), 32'd1);

      // Asynchronous reset mid-group
      do_reset();
      out_ready = 1'b0;
      send(2'b11); send(2'b10); send(2'b10); send(2'b10); send(2'b10);
      send(2'b10); send(2'b10); send(2'b10);
      in_valid = 1'b0;
      check("pre_arst_grp", 32'(out_grp_a), 32'h2A8);
      check("pre_arst_err", 32'(err_a), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid_a), 32'd0);
      check("arst_grp", 32'(out_grp_a), 32'd0);
      check("arst_err", 32'(err_a), 32'd0);
      #1 rst = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      check("arst_in_ready", 32'(in_ready_a), 32'd1);
      for (int i = 0; i < 5; i++) send(2'b10);
      in_valid = 1'b0;
      check("post_arst_grp", {21'd0, out_last_a, out_grp_a}, 32'h2AA);

      // Short polynomial (7 coefficients) on the second instance
      do_reset();
      use_b = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         send(2'b10);
         if (i == 5) check("n7_g1", {21'd0, out_last_b, out_grp_b}, 32'h2AA);
      end
      in_valid = 1'b0;
      check("n7_g2", {21'd0, out_last_b, out_grp_b}, 32'h40A);
      @(negedge clk);
      check("n7_poly_done", 32'(poly_done_b), 32'd1);
      @(negedge clk);
      check("n7_poly_done_lo", 32'(poly_done_b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
